uart_tx_datapath: RTL and testbench
===================================

Name: uart_tx_datapath

Overview:
- UART transmitter datapath; sits directly downstream of the TX control FSM and consumes its ser_en / mux_sel / Busy.
- Captures the parallel word and computes its parity bit.
- Serialises data LSB-first, returns ser_done to the FSM, and drives the registered serial line TX_OUT.
- Frame on the line: start bit, data bits, optional parity, stop/idle.

Parameters:
- DATA_WIDTH, 8, parallel word width and number of data bits per frame (legal 5..9).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- P_DATA  in  DATA_WIDTH  parallel word to transmit.
- DATA_VALID  in  1  P_DATA valid strobe.
- PAR_EN  in  1  parity enable, sampled at capture.
- PAR_TYP  in  1  parity type, sampled at capture: 0 even, 1 odd.
- Busy  in  1  FSM busy; capture is blocked while high.
- ser_en  in  1  FSM serializer enable.
- mux_sel  in  2  FSM line select: 00 start, 01 idle/stop, 10 data, 11 parity.
- ser_done  out  1  last data bit is being selected (combinational).
- TX_OUT  out  1  serial line (registered).

Behaviour:
- Reset (RST=1 at a CLK edge): data_reg=0, par_bit=0, bit_cnt=0, TX_OUT=1.
  - No output toggles until RST is low.
  - Reset mid-frame abandons the frame; the line returns to 1 on the next edge.
- Capture: on an edge with DATA_VALID=1 and Busy=0:
  - data_reg <= P_DATA.
  - par_bit <= (^P_DATA) ^ PAR_TYP.
  - PAR_EN is not needed by the datapath; the FSM decides whether the parity phase happens.
- DATA_VALID while Busy=1 is ignored: data_reg is unchanged and no error is flagged.
- Capture coincides with the FSM's IDLE->Start edge, so data_reg is stable for the whole frame.
- Serializer:
  - Active only when mux_sel==10.
  - Current bit = data_reg[bit_cnt] (LSB-first; data_reg itself is not shifted).
  - Edge with mux_sel==10 and ser_en=1: bit_cnt <= bit_cnt+1.
  - Edge with mux_sel!=10: bit_cnt <= 0.
  - ser_en=1 during Start (mux_sel=00) does not advance the count.
- ser_done = (mux_sel==10) && (bit_cnt==DATA_WIDTH-1).
  - Must not depend on ser_en, because the FSM derives ser_en from ser_done; no combinational loop is allowed.
  - The FSM therefore holds the data phase for exactly DATA_WIDTH cycles.
- bit_cnt width = clog2(DATA_WIDTH). The count saturates at DATA_WIDTH-1 (cannot wrap) even if ser_en stays high.
- Line mux: next_tx is selected by mux_sel:
  - 00 -> 0 (start bit).
  - 01 -> 1 (idle/stop).
  - 10 -> data_reg[bit_cnt].
  - 11 -> par_bit.
- TX_OUT <= next_tx every edge, giving a fixed 1-cycle latency from mux_sel to the line.
- Frame length on TX_OUT: 1 + DATA_WIDTH + PAR_EN bits, then at least 1 idle/stop cycle.
- Back-to-back frames: a new capture is possible on the first edge after Busy falls.
- Simultaneous RST and DATA_VALID: reset wins.

Decomposition:
- Shared package uart_tx_pkg holds:
  - MUX_START=2'b00, MUX_IDLE=2'b01, MUX_DATA=2'b10, MUX_PARITY=2'b11.
  - PAR_EVEN=1'b0, PAR_ODD=1'b1.
  - The FSM uses the same constants.
- One sub-module, uart_tx_serializer: bit_cnt, the bit select and ser_done.
- Top level keeps capture, parity and the output register.

Test Plan:
- Reset: RST=1 for 2 cycles with random inputs -> TX_OUT=1, ser_done=0; after release with mux_sel=01, TX_OUT stays 1.
- Even parity: DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, driven with the FSM -> TX_OUT = 0,1,0,1,0,0,1,0,1,0 then 1. ser_done is high exactly in the 8th data cycle.
- Odd parity / no parity:
  - P_DATA=0x01, PAR_TYP=1, PAR_EN=1 -> parity bit 0.
  - Same word with PAR_EN=0 -> 0,1,0,0,0,0,0,0,0 then 1; frame is 9 bits plus stop.
- Busy blocking: DATA_VALID with P_DATA=0x3C mid-frame (Busy=1) -> the transmitted word remains the first one; 0x3C is not sent.
- Mid-frame reset: RST during data bit 4 -> TX_OUT=1 next cycle, bit_cnt=0. The next frame 0xFF sends a full 8 ones after the start bit.
- Back-to-back: DATA_VALID on the first cycle Busy=0 after a frame -> second start bit follows exactly one stop cycle; ser_done never asserts outside mux_sel=10.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter (datapath and TX control FSM).
// Contents: line-select encodings driven on mux_sel and parity-type encodings.
package uart_tx_pkg;

    localparam int unsigned MUX_SEL_W = 2;

    // Line select encodings shared with the TX control FSM
    localparam logic [MUX_SEL_W-1:0] MUX_START  = 2'b00;
    localparam logic [MUX_SEL_W-1:0] MUX_IDLE   = 2'b01;
    localparam logic [MUX_SEL_W-1:0] MUX_DATA   = 2'b10;
    localparam logic [MUX_SEL_W-1:0] MUX_PARITY = 2'b11;

    // Parity type encodings on PAR_TYP
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_datapath_if.sv
// Bundle between the TX control FSM (master) and the TX datapath (slave).
// Signals:
//   P_DATA, DATA_VALID, PAR_EN, PAR_TYP  word to send and its framing options
//   Busy, ser_en, mux_sel                FSM state seen by the datapath
//   ser_done                             last data bit selected (combinational)
//   TX_OUT                               registered serial line
// PAR_EN belongs to the FSM side only: it decides whether a parity phase is
// sequenced, so the datapath modport does not carry it.
interface uart_tx_datapath_if
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  Busy;
    logic                  ser_en;
    logic [MUX_SEL_W-1:0]  mux_sel;
    logic                  ser_done;
    logic                  TX_OUT;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Busy, ser_en, mux_sel,
        input  ser_done, TX_OUT
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_TYP, Busy, ser_en, mux_sel,
        output ser_done, TX_OUT
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first bit selector for the data phase of a UART frame.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mux_sel      FSM line select; counting only happens in the data phase
//   ser_en       advance to the next data bit
//   data         captured word (never shifted, indexed by the bit counter)
//   ser_bit_c    currently selected data bit (combinational)
//   ser_done_c   last data bit is selected (combinational, independent of ser_en)
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MUX_SEL_W-1:0]  mux_sel,
    input  logic                  ser_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ser_bit_c,
    output logic                  ser_done_c
);

    localparam int unsigned    CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [CNT_W-1:0] bit_cnt;

    // Bit counter: cleared outside the data phase, saturates on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (mux_sel != MUX_DATA) begin
            bit_cnt <= '0;
        end else if (ser_en && (bit_cnt != LAST_BIT)) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign ser_bit_c  = data[bit_cnt];
    // ser_en is deliberately excluded: the FSM derives ser_en from this flag
    assign ser_done_c = (mux_sel == MUX_DATA) && (bit_cnt == LAST_BIT);

endmodule

// File: rtl/uart_tx_datapath.sv
// UART transmitter datapath: captures the word, computes parity, serialises
// LSB-first and drives the registered line.
// Ports:
//   CLK  system clock, all state on the rising edge
//   RST  synchronous active-high reset
//   bus  slave side of uart_tx_datapath_if (data/handshake in, ser_done/TX_OUT out)
module uart_tx_datapath
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_datapath_if.slave  bus
);

    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_bit;
    logic                  ser_bit;
    logic                  ser_done;
    logic                  next_tx;

    // Capture word and parity on the FSM's IDLE->Start edge; ignored while busy
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg <= '0;
            par_bit  <= 1'b0;
        end else if (bus.DATA_VALID && !bus.Busy) begin
            data_reg <= bus.P_DATA;
            par_bit  <= (^bus.P_DATA) ^ bus.PAR_TYP;
        end
    end

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk        (CLK),
        .rst        (RST),
        .mux_sel    (bus.mux_sel),
        .ser_en     (bus.ser_en),
        .data       (data_reg),
        .ser_bit_c  (ser_bit),
        .ser_done_c (ser_done)
    );

    assign bus.ser_done = ser_done;

    // Line mux
    always_comb begin
        next_tx = 1'b1;
        unique case (bus.mux_sel)
            MUX_START:  next_tx = 1'b0;
            MUX_IDLE:   next_tx = 1'b1;
            MUX_DATA:   next_tx = ser_bit;
            MUX_PARITY: next_tx = par_bit;
            default:    next_tx = 1'b1;
        endcase
    end

    // Registered line: fixed one-cycle latency from mux_sel
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.TX_OUT <= 1'b1;
        end else begin
            bus.TX_OUT <= next_tx;
        end
    end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Self-checking bench for uart_tx_datapath: an FSM-like driver sequences
// frames, a per-cycle reference model checks TX_OUT and ser_done, and frame
// level expectations (literal or computed from the word) check whole frames.
module tb_uart_tx_datapath;
    import uart_tx_pkg::*;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_datapath_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_datapath #(.DATA_WIDTH(DW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rw();
        return DW'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Reference model: captured word, its parity, index of the selected data bit
    logic [DW-1:0] m_word;
    logic          m_par;
    int            m_idx;
    logic          m_exp_tx;
    bit            m_valid = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (m_valid) begin
            chk("tx_line", 32'(bus.TX_OUT), 32'(m_exp_tx));
            chk("ser_done", 32'(bus.ser_done),
                32'((bus.mux_sel == MUX_DATA) && (m_idx == DW - 1)));
        end
        if (rst) begin
            m_exp_tx = 1'b1;
            m_word   = '0;
            m_par    = 1'b0;
            m_idx    = 0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            case (bus.mux_sel)
                MUX_START:  m_exp_tx = 1'b0;
                MUX_IDLE:   m_exp_tx = 1'b1;
                MUX_DATA:   m_exp_tx = m_word[m_idx];
                default:    m_exp_tx = m_par;
            endcase
            if (bus.DATA_VALID && !bus.Busy) begin
                m_word = bus.P_DATA;
                m_par  = (^bus.P_DATA) ^ bus.PAR_TYP;
            end
            if (bus.mux_sel != MUX_DATA) m_idx = 0;
            else if (bus.ser_en && (m_idx < DW - 1)) m_idx = m_idx + 1;
        end
    end

    // One clock of stimulus; returns ser_done before the edge and TX_OUT after it
    task automatic cyc(input logic [1:0] m, input logic en, input logic bsy, input logic dv,
                       input logic [DW-1:0] pd, input logic pt, input logic pe, input logic r,
                       output logic tx, output logic dn);
        @(negedge clk);
        bus.mux_sel    = m;
        bus.ser_en     = en;
        bus.Busy       = bsy;
        bus.DATA_VALID = dv;
        bus.P_DATA     = pd;
        bus.PAR_TYP    = pt;
        bus.PAR_EN     = pe;
        rst            = r;
        #1 dn = bus.ser_done;
        @(posedge clk);
        #1 tx = bus.TX_OUT;
    endtask

    task automatic capture(input logic [DW-1:0] w, input logic pt, input logic pe);
        logic tx, dn;
        cyc(MUX_IDLE, 1'b0, 1'b0, 1'b1, w, pt, pe, 1'b0, tx, dn);
    endtask

    // Start, data, optional parity, stop; optional capture of the next word in the stop cycle
    task automatic run_frame(input logic pen, input logic inject, input logic chain,
                             input logic [DW-1:0] cw, input logic cpt,
                             output logic [15:0] bits, output int n, output logic [DW-1:0] done);
        logic tx, dn;
        bits = '0;
        n    = 0;
        done = '0;
        cyc(MUX_START, rb(), 1'b1, 1'b0, rw(), rb(), pen, 1'b0, tx, dn);
        bits[n] = tx; n++;
        for (int i = 0; i < DW; i++) begin
            cyc(MUX_DATA, 1'b1, 1'b1, inject && (i == 3),
                (inject && (i == 3)) ? DW'(8'h3C) : rw(), rb(), pen, 1'b0, tx, dn);
            bits[n] = tx; n++;
            done[i] = dn;
        end
        if (pen) begin
            cyc(MUX_PARITY, rb(), 1'b1, 1'b0, rw(), rb(), pen, 1'b0, tx, dn);
            bits[n] = tx; n++;
        end
        cyc(MUX_IDLE, rb(), !chain, chain, chain ? cw : rw(), cpt, pen, 1'b0, tx, dn);
        bits[n] = tx; n++;
    endtask

    initial begin
        logic [15:0]   bits;
        logic [15:0]   ef;
        int            n;
        logic [DW-1:0] done;
        logic [DW-1:0] w;
        logic          tx, dn, pen, pt;

        rst            = 1'b1;
        bus.mux_sel    = MUX_IDLE;
        bus.ser_en     = 1'b0;
        bus.Busy       = 1'b0;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = '0;
        bus.PAR_TYP    = 1'b0;
        bus.PAR_EN     = 1'b0;

        // Reset with random inputs, then idle
        for (int i = 0; i < 2; i++) begin
            cyc(2'($urandom), rb(), rb(), rb(), rw(), rb(), rb(), 1'b1, tx, dn);
            chk("reset_tx", 32'(tx), 32'd1);
            chk("reset_done", 32'(dn), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(MUX_IDLE, 1'b0, 1'b0, 1'b0, rw(), rb(), rb(), 1'b0, tx, dn);
            chk("idle_after_reset", 32'(tx), 32'd1);
        end

        // 0xA5 with even parity
        capture(8'hA5, PAR_EVEN, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0, '0, 1'b0, bits, n, done);
        chk("a5_even_frame", 32'(bits), 32'h54A);
        chk("a5_even_len", 32'(n), 32'd11);
        chk("a5_done_mask", 32'(done), 32'h80);

        // 0x01 odd parity, then without parity
        capture(8'h01, PAR_ODD, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0, '0, 1'b0, bits, n, done);
        chk("01_odd_frame", 32'(bits), 32'h402);
        capture(8'h01, PAR_ODD, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0, '0, 1'b0, bits, n, done);
        chk("01_nopar_frame", 32'(bits), 32'h202);
        chk("01_nopar_len", 32'(n), 32'd10);

        // DATA_VALID with 0x3C while busy is ignored
        capture(8'h96, PAR_ODD, 1'b1);
        run_frame(1'b1, 1'b1, 1'b0, '0, 1'b0, bits, n, done);
        chk("busy_block_frame", 32'(bits), 32'h72C);

        // Reset during data bit 4
        capture(8'h0F, PAR_EVEN, 1'b0);
        cyc(MUX_START, 1'b1, 1'b1, 1'b0, rw(), 1'b0, 1'b0, 1'b0, tx, dn);
        for (int i = 0; i < 4; i++) cyc(MUX_DATA, 1'b1, 1'b1, 1'b0, rw(), 1'b0, 1'b0, 1'b0, tx, dn);
        cyc(MUX_DATA, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, tx, dn);
        chk("midframe_reset_tx", 32'(tx), 32'd1);
        cyc(MUX_DATA, 1'b0, 1'b1, 1'b0, rw(), 1'b0, 1'b0, 1'b0, tx, dn);
        chk("reset_clears_data", 32'(tx), 32'd0);
        chk("reset_clears_cnt", 32'(dn), 32'd0);
        cyc(MUX_IDLE, 1'b0, 1'b0, 1'b0, rw(), 1'b0, 1'b0, 1'b0, tx, dn);
        capture(8'hFF, PAR_EVEN, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0, '0, 1'b0, bits, n, done);
        chk("ff_after_reset_frame", 32'(bits), 32'h3FE);

        // Back-to-back: next word captured in the stop cycle
        capture(8'hC3, PAR_EVEN, 1'b1);
        run_frame(1'b1, 1'b0, 1'b1, 8'h5A, PAR_EVEN, bits, n, done);
        chk("b2b_first_frame", 32'(bits), 32'h586);
        run_frame(1'b0, 1'b0, 1'b0, '0, 1'b0, bits, n, done);
        chk("b2b_second_frame", 32'(bits), 32'h2B4);

        // Counter saturation with ser_en held high past the last bit
        capture(8'h80, PAR_EVEN, 1'b0);
        cyc(MUX_START, 1'b1, 1'b1, 1'b0, rw(), 1'b0, 1'b0, 1'b0, tx, dn);
        for (int i = 0; i < DW + 3; i++) begin
            cyc(MUX_DATA, 1'b1, 1'b1, 1'b0, rw(), 1'b0, 1'b0, 1'b0, tx, dn);
            if (i >= DW - 1) begin
                chk("saturate_tx", 32'(tx), 32'd1);
                chk("saturate_done", 32'(dn), 32'd1);
            end
        end
        cyc(MUX_IDLE, 1'b0, 1'b0, 1'b0, rw(), 1'b0, 1'b0, 1'b0, tx, dn);

        // Random frames against a frame-level expectation
        for (int f = 0; f < 30; f++) begin
            w   = rw();
            pen = rb();
            pt  = rb();
            capture(w, pt, pen);
            run_frame(pen, rb(), 1'b0, '0, 1'b0, bits, n, done);
            if (pen) ef = {5'b0, 1'b1, (^w) ^ pt, w, 1'b0};
            else     ef = {6'b0, 1'b1, w, 1'b0};
            chk("random_frame", 32'(bits), 32'(ef));
            chk("random_done_mask", 32'(done), 32'h80);
        end

        // Unconstrained random cycles, including occasional resets
        for (int i = 0; i < 300; i++) begin
            cyc(2'($urandom), rb(), rb(), rb(), rw(), rb(), rb(),
                ($urandom_range(15) == 0), tx, dn);
        end
        cyc(MUX_IDLE, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, tx, dn);
        @(negedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
